cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
Single-port memory arbiter between the instruction cache and the data cache of one core. It grants the shared RAM port to one requester at a time and steers address, store data, and read/write enables to RAM. It returns load data and per-requester wait, and flags accesses that stall too long. It sits between icache/dcache and the RAM model or memory controller.

Parameters:
WORD_W, 32, address/data width (matches word_t)
TIMEOUT, 255, cycles spent in a SERVE state without ACCESS before err is raised
TCNT_W, 8, width of timeout counter; must satisfy 2^TCNT_W > TIMEOUT

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
iREN  in  1  icache read request
iaddr  in  WORD_W  icache address
iwait  out  1  high = icache must hold request
iload  out  WORD_W  icache read data
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  WORD_W  dcache address
dstore  in  WORD_W  dcache write data
dwait  out  1  high = dcache must hold request
dload  out  WORD_W  dcache read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
err  out  1  sticky error: timeout or RAM ERROR seen

Behaviour:
- Reset (async, RST=1): state=IDLE, last=SERVED_I (so dcache wins first tie), tcnt=0, err=0. Outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
- ireq = iREN. dreq = dREN|dWEN. If dREN and dWEN are both high, treat as a write (ramWEN=1, ramREN=0).
- States: IDLE, SERVE_I, SERVE_D (arb_state_t).
- IDLE:
  - No RAM enables; both waits high.
  - Next state: dreq&&!ireq -> SERVE_D; ireq&&!dreq -> SERVE_I; both -> grant the requester not equal to last; none -> stay.
- SERVE_x, combinational outputs from the granted requester's live inputs:
  - ramaddr/ramstore/ramREN/ramWEN follow the granted requester each cycle. Address changes mid-service pass through.
  - The non-granted requester sees wait=1 and load=0.
- Completion (ramstate==ACCESS in SERVE_x):
  - granted wait=0 for exactly that cycle; x-load=ramload.
  - Next: IDLE, last<=x, tcnt<=0.
  - Latency: minimum 1 cycle in SERVE_x plus 1 IDLE bubble between consecutive grants.
- Withdrawal: granted requester drops all enables before ACCESS -> IDLE next cycle, no ack, last unchanged, tcnt<=0.
- ramstate==ERROR in SERVE_x: err<=1; IDLE next cycle; wait stays high; last unchanged, so the requester re-arbitrates/retries.
- Timeout:
  - tcnt increments each SERVE cycle without ACCESS and saturates at TIMEOUT.
  - Reaching TIMEOUT sets err<=1; the access is not aborted.
  - err clears only on RST.
- FREE/BUSY in SERVE_x: hold state, keep driving.
- Reset mid-service: immediate return to reset values; the in-flight RAM access is abandoned.

Decomposition:
- cpu_types_pkg: word_t, ramstate_t (existing); add arb_state_t {IDLE, SERVE_I, SERVE_D} and served_t {SERVED_I, SERVED_D}.
- One natural sub-module: access_timer (saturating counter with clear, enable, and a TIMEOUT compare output), reused later by the bus controller.

Test Plan:
- Reset with RST=1 mid-access -> ramREN=ramWEN=0, iwait=dwait=1, err=0, state IDLE on the same edge/asynchronously.
- iREN=1, iaddr=0x0000_0040, ramstate BUSY for 2 cycles then ACCESS, ramload=0x2402_0005 -> ramaddr=0x40, ramREN=1; iwait=0 and iload=0x2402_0005 in the ACCESS cycle only.
- iREN, dREN, and dWEN asserted together after reset, daddr=0x80, dstore=0xDEAD_BEEF -> dcache first (ramWEN=1, ramREN=0, ramstore=0xDEADBEEF), then 1 IDLE cycle, then icache served (round-robin).
- Continuous iREN and dREN with ACCESS every cycle -> grants alternate D, I, D, I; no requester waits more than 2 grants.
- dREN held, ramstate BUSY for 255 cycles -> err rises on the cycle tcnt reaches 255; dwait remains 1; later ACCESS completes normally; err stays 1.
- ramstate=ERROR during SERVE_I -> err=1, iwait stays 1, IDLE next cycle; a retry with ACCESS completes with iwait=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, RAM handshake state, arbiter FSM types.
// Imported by the memory arbiter, its interface and the bench.
package cpu_types_pkg;

   parameter int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FREE,
      BUSY,
      ACCESS,
      ERROR
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D
   } arb_state_t;

   typedef enum logic {
      SERVED_I,
      SERVED_D
   } served_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache/RAM bus bundle seen by the memory arbiter.
// slave: arbiter view (cache reqs + ram status in); master: environment view.
interface cache_mem_arbiter_if #(
   parameter int WORD_W = 32
);
   import cpu_types_pkg::*;

   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;

   logic              dREN;
   logic              dWEN;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              dwait;
   logic [WORD_W-1:0] dload;

   logic              ramREN;
   logic              ramWEN;
   logic [WORD_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   ramstate_t         ramstate;

   modport slave (
      input  iREN, iaddr,
      input  dREN, dWEN, daddr, dstore,
      input  ramload, ramstate,
      output iwait, iload,
      output dwait, dload,
      output ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr,
      output dREN, dWEN, daddr, dstore,
      output ramload, ramstate,
      input  iwait, iload,
      input  dwait, dload,
      input  ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/cache_mem_arbiter_timer.sv
// access_timer: saturating cycle counter with clear/enable.
// Ports: clk, rst (async high), clr, en in; done = count at TIMEOUT.
module access_timer #(
   parameter int TIMEOUT = 255,
   parameter int TCNT_W  = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam logic [TCNT_W-1:0] MAX = TCNT_W'(TIMEOUT);

   logic [TCNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign done = (cnt == MAX);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache, round-robin on ties.
// Ports: CLK, RST (async high), bus (cache + RAM signals), err (sticky).
module cache_mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int WORD_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int TCNT_W  = 8
) (
   input  logic                CLK,
   input  logic                RST,
   cache_mem_arbiter_if.slave  bus,
   output logic                err
);

   arb_state_t state, state_nxt;
   served_t    last, last_nxt;
   logic       err_q;

   logic ireq, dreq;
   logic serve, gnt_i, gnt_req;
   logic withdraw, access, ram_err;
   logic tclr, tdone;

   assign ireq    = bus.iREN;
   assign dreq    = bus.dREN | bus.dWEN;
   assign serve   = (state == SERVE_I) || (state == SERVE_D);
   assign gnt_i   = (state == SERVE_I);
   assign gnt_req = gnt_i ? ireq : dreq;

   // Withdrawal wins over any RAM status: nothing was really asked for.
   assign withdraw = serve && !gnt_req;
   assign access   = serve && gnt_req
                  && (bus.ramstate == ACCESS);
   assign ram_err  = serve && gnt_req
                  && (bus.ramstate == ERROR);

   assign tclr = !serve || withdraw || access || ram_err;

   access_timer #(
      .TIMEOUT (TIMEOUT),
      .TCNT_W  (TCNT_W)
   ) u_timer (
      .clk  (CLK),
      .rst  (RST),
      .clr  (tclr),
      .en   (serve),
      .done (tdone)
   );

   // err goes high in the very cycle the counter saturates; err_q holds it.
   assign err = err_q | tdone;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         last  <= SERVED_I;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         err_q <= err_q | tdone | ram_err;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      unique case (state)
         IDLE: begin
            if (dreq && !ireq) begin
               state_nxt = SERVE_D;
            end else if (ireq && !dreq) begin
               state_nxt = SERVE_I;
            end else if (ireq && dreq) begin
               state_nxt = (last == SERVED_I) ? SERVE_D
                                              : SERVE_I;
            end
         end
         SERVE_I, SERVE_D: begin
            if (withdraw || access || ram_err) begin
               state_nxt = IDLE;
            end
            if (access) begin
               last_nxt = gnt_i ? SERVED_I : SERVED_D;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      bus.iload    = '0;
      bus.dload    = '0;
      unique case (1'b1)
         (state == SERVE_I): begin
            bus.ramREN  = bus.iREN;
            bus.ramaddr = bus.iaddr;
            if (access) begin
               bus.iwait = 1'b0;
               bus.iload = bus.ramload;
            end
         end
         (state == SERVE_D): begin
            // Read+write together is a write.
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN & ~bus.dWEN;
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            if (access) begin
               bus.dwait = 1'b0;
               bus.dload = bus.ramload;
            end
         end
         default: begin
         end
      endcase
   end

endmodule
